// File: rtl/flight_pkg.sv
// Shared encodings for the flight command path: command codes, one-hot
// mode/position selects and the controller state type.
package flight_pkg;

  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_RESET   = 3'd1;
  localparam logic [2:0] CMD_ATTACK  = 3'd2;
  localparam logic [2:0] CMD_DEFENSE = 3'd3;
  localparam logic [2:0] CMD_STEALTH = 3'd4;
  localparam logic [2:0] CMD_WARP    = 3'd5;

  localparam logic [3:0] MODE_RESET   = 4'b0001;
  localparam logic [3:0] MODE_ATTACK  = 4'b0010;
  localparam logic [3:0] MODE_DEFENSE = 4'b0100;
  localparam logic [3:0] MODE_STEALTH = 4'b1000;

  localparam logic [3:0] POS_RESET  = 4'b0001;
  localparam logic [3:0] POS_NORMAL = 4'b0010;
  localparam logic [3:0] POS_WARP   = 4'b0100;

  typedef enum logic [2:0] {
    ST_RESET       = 3'd0,
    ST_ATTACK      = 3'd1,
    ST_DEFENSE     = 3'd2,
    ST_STEALTH     = 3'd3,
    ST_WARP_CHARGE = 3'd4,
    ST_WARP        = 3'd5
  } flight_state_t;

  function automatic logic [3:0] mode_onehot(input flight_state_t s);
    case (s)
      ST_ATTACK:  mode_onehot = MODE_ATTACK;
      ST_DEFENSE: mode_onehot = MODE_DEFENSE;
      ST_STEALTH: mode_onehot = MODE_STEALTH;
      default:    mode_onehot = MODE_RESET;
    endcase
  endfunction

  function automatic flight_state_t cmd_to_state(input logic [2:0] c);
    case (c)
      CMD_ATTACK:  cmd_to_state = ST_ATTACK;
      CMD_DEFENSE: cmd_to_state = ST_DEFENSE;
      CMD_STEALTH: cmd_to_state = ST_STEALTH;
      default:     cmd_to_state = ST_RESET;
    endcase
  endfunction

endpackage

// File: rtl/flight_mode_controller_cycle_counter.sv
// Loadable down-counter that saturates at zero; clear has priority over load.
module cycle_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             clear_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/flight_mode_controller.sv
// Flight command controller: accepts commands and drives the one-hot mode and
// position selects for all axes, with cooldown, warp charge and stealth limit.
module flight_mode_controller
  import flight_pkg::*;
#(
  parameter int COOLDOWN    = 4,
  parameter int WARP_CHARGE = 8,
  parameter int STEALTH_MAX = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  output logic       cmd_ready,
  output logic [3:0] mode_sel,
  output logic [3:0] pos_sel,
  output logic       warp_busy,
  output logic       stealth_timeout,
  output logic       cmd_err
);

  // Counters hold the cycles remaining after the current one, hence the -1.
  localparam logic [CNT_W-1:0] COOL_LD = CNT_W'(COOLDOWN - 1);
  localparam logic [CNT_W-1:0] CHG_LD  = CNT_W'(WARP_CHARGE - 1);
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(STEALTH_MAX - 1);

  flight_state_t    state_q, state_d, saved_q, saved_d;
  logic [CNT_W-1:0] st_cnt_q, st_cnt_d;
  logic [3:0]       mode_sel_q, mode_sel_d, pos_sel_q, pos_sel_d;
  logic             cmd_ready_q, cmd_ready_d, warp_busy_q, warp_busy_d;
  logic             timeout_q, timeout_d, cmd_err_q, cmd_err_d;
  logic             accept_s, is_mode_s;
  logic             cd_load_s, cd_clear_s, cd_zero_s;
  logic             ch_load_s, ch_clear_s, ch_zero_s;

  assign accept_s  = cmd_valid && (cmd_ready_q || (cmd == CMD_RESET));
  assign is_mode_s = (cmd == CMD_ATTACK) || (cmd == CMD_DEFENSE) || (cmd == CMD_STEALTH);

  cycle_counter #(.CNT_W(CNT_W)) u_cooldown (
    .clk(clk), .rst_n(rst_n), .load_i(cd_load_s), .load_val_i(COOL_LD),
    .clear_i(cd_clear_s), .zero_o(cd_zero_s)
  );

  cycle_counter #(.CNT_W(CNT_W)) u_charge (
    .clk(clk), .rst_n(rst_n), .load_i(ch_load_s), .load_val_i(CHG_LD),
    .clear_i(ch_clear_s), .zero_o(ch_zero_s)
  );

  // Next-state: RESET, then accepted mode change, then warp, then timed events.
  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    cd_load_s  = 1'b0;
    cd_clear_s = 1'b0;
    ch_load_s  = 1'b0;
    ch_clear_s = 1'b0;
    timeout_d  = 1'b0;
    cmd_err_d  = accept_s && ((cmd > CMD_WARP) ||
                              ((cmd == CMD_WARP) && (state_q == ST_RESET)));
    if (accept_s && (cmd == CMD_RESET)) begin
      state_d    = ST_RESET;
      cd_clear_s = 1'b1;
      ch_clear_s = 1'b1;
    end else if (accept_s && is_mode_s && (cmd_to_state(cmd) != state_q)) begin
      state_d   = cmd_to_state(cmd);
      cd_load_s = 1'b1;
    end else if (accept_s && (cmd == CMD_WARP) && (state_q != ST_RESET)) begin
      saved_d   = state_q;
      state_d   = ST_WARP_CHARGE;
      ch_load_s = 1'b1;
    end else begin
      case (state_q)
        ST_WARP_CHARGE: begin
          if (ch_zero_s) state_d = ST_WARP;
          else           state_d = state_q;
        end
        ST_WARP: begin
          state_d   = saved_q;
          cd_load_s = 1'b1;
        end
        ST_STEALTH: begin
          if (st_cnt_q == ST_LAST) begin
            state_d   = ST_DEFENSE;
            cd_load_s = 1'b1;
            timeout_d = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Output decode from the next state, plus the stealth dwell counter.
  always_comb begin
    warp_busy_d = (state_d == ST_WARP_CHARGE) || (state_d == ST_WARP);
    mode_sel_d  = warp_busy_d ? mode_onehot(saved_d) : mode_onehot(state_d);
    case (state_d)
      ST_RESET: pos_sel_d = POS_RESET;
      ST_WARP:  pos_sel_d = POS_WARP;
      default:  pos_sel_d = POS_NORMAL;
    endcase
    cmd_ready_d = !warp_busy_d && !cd_load_s && (cd_clear_s || cd_zero_s);
    if ((state_q == ST_STEALTH) && (state_d == ST_STEALTH)) begin
      st_cnt_d = (st_cnt_q != '1) ? (st_cnt_q + CNT_W'(1)) : st_cnt_q;
    end else begin
      st_cnt_d = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      saved_q     <= ST_RESET;
      st_cnt_q    <= '0;
      mode_sel_q  <= MODE_RESET;
      pos_sel_q   <= POS_RESET;
      cmd_ready_q <= 1'b1;
      warp_busy_q <= 1'b0;
      timeout_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      st_cnt_q    <= st_cnt_d;
      mode_sel_q  <= mode_sel_d;
      pos_sel_q   <= pos_sel_d;
      cmd_ready_q <= cmd_ready_d;
      warp_busy_q <= warp_busy_d;
      timeout_q   <= timeout_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign mode_sel        = mode_sel_q;
  assign pos_sel         = pos_sel_q;
  assign warp_busy       = warp_busy_q;
  assign stealth_timeout = timeout_q;
  assign cmd_err         = cmd_err_q;

endmodule

// File: tb/tb_flight_mode_controller.sv
// Directed and random stimulus checked against a timestamp-based reference
// model of the flight controller rules.
module tb_flight_mode_controller;
  import flight_pkg::*;

  localparam int COOLDOWN    = 4;
  localparam int WARP_CHARGE = 8;
  localparam int STEALTH_MAX = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       cmd_ready, warp_busy, stealth_timeout, cmd_err;
  logic [3:0] mode_sel, pos_sel;

  int errors = 0;
  int checks = 0;

  // Model: mode index 0..3, phase 0 normal / 1 charging / 2 warp, absolute cycle stamps.
  int m_n, m_mode, m_phase, m_ready_from, m_charge_end, m_stealth_start;
  logic       e_to, e_err;

  flight_mode_controller #(
    .COOLDOWN(COOLDOWN), .WARP_CHARGE(WARP_CHARGE), .STEALTH_MAX(STEALTH_MAX), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_ready(cmd_ready), .mode_sel(mode_sel), .pos_sel(pos_sel),
    .warp_busy(warp_busy), .stealth_timeout(stealth_timeout), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_mode = 0; m_phase = 0; m_ready_from = 0;
    m_charge_end = 0; m_stealth_start = 0; e_to = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [2:0] c);
    int  p  = m_n;
    int  ci = int'(c);
    bit  rdy = (m_phase == 0) && (p >= m_ready_from);
    bit  acc = v && (rdy || ci == 1);
    m_n   = p + 1;
    e_to  = 1'b0;
    e_err = acc && (ci >= 6 || (ci == 5 && m_mode == 0));
    if (acc && ci == 1) begin
      m_mode = 0; m_phase = 0; m_ready_from = m_n;
    end else if (acc && ci >= 2 && ci <= 4 && (ci - 1) != m_mode) begin
      m_mode = ci - 1; m_ready_from = m_n + COOLDOWN; m_stealth_start = m_n;
    end else if (acc && ci == 5 && m_mode != 0) begin
      m_phase = 1; m_charge_end = m_n + WARP_CHARGE - 1;
    end else if (m_phase == 1) begin
      if (p == m_charge_end) m_phase = 2;
    end else if (m_phase == 2) begin
      m_phase = 0; m_ready_from = m_n + COOLDOWN; m_stealth_start = m_n;
    end else if (m_mode == 3 && (p - m_stealth_start + 1) == STEALTH_MAX) begin
      m_mode = 2; e_to = 1'b1; m_ready_from = m_n + COOLDOWN;
    end
  endtask

  task automatic check_model();
    logic [3:0] em, ep;
    em = 4'b0001 << m_mode;
    ep = (m_mode == 0) ? 4'b0001 : ((m_phase == 2) ? 4'b0100 : 4'b0010);
    chk("mode_sel", 32'(mode_sel), 32'(em));
    chk("pos_sel", 32'(pos_sel), 32'(ep));
    chk("warp_busy", 32'(warp_busy), 32'(m_phase != 0));
    chk("cmd_ready", 32'(cmd_ready), 32'((m_phase == 0) && (m_n >= m_ready_from)));
    chk("stealth_timeout", 32'(stealth_timeout), 32'(e_to));
    chk("cmd_err", 32'(cmd_err), 32'(e_err));
  endtask

  task automatic step(input logic v, input logic [2:0] c);
    cmd_valid = v;
    cmd       = c;
    @(posedge clk);
    #1;
    model_step(v, c);
    check_model();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 40 && !cmd_ready; i++) step(1'b0, CMD_NOP);
    chk("ready_reached", 32'(cmd_ready), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mode"}, 32'(mode_sel), 32'h1);
    chk({tag, "_pos"}, 32'(pos_sel), 32'h1);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(warp_busy), 32'd0);
    chk({tag, "_pulses"}, 32'({stealth_timeout, cmd_err}), 32'd0);
  endtask

  initial begin
    int low_cnt, chg_cnt, st_cnt, to_cnt, r;
    logic [2:0] rc;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = CMD_NOP;
    #12;
    check_reset_values("reset");
    rst_n = 1'b1;
    model_reset();

    // Mode change and cooldown length
    step(1'b1, CMD_ATTACK);
    chk("attack_mode", 32'(mode_sel), 32'h2);
    low_cnt = cmd_ready ? 0 : 1;
    for (int i = 0; i < 20 && !cmd_ready; i++) begin
      step(1'b0, CMD_NOP);
      if (!cmd_ready) low_cnt++;
    end
    chk("cooldown_len", 32'(low_cnt), 32'(COOLDOWN));

    // Warp from ATTACK
    step(1'b1, CMD_WARP);
    chg_cnt = 0;
    for (int i = 0; i < 30 && warp_busy && pos_sel == 4'b0010; i++) begin
      chg_cnt++;
      step(1'b0, CMD_NOP);
    end
    chk("charge_len", 32'(chg_cnt), 32'(WARP_CHARGE));
    chk("warp_pos", 32'(pos_sel), 32'h4);
    step(1'b0, CMD_NOP);
    chk("warp_return_mode", 32'(mode_sel), 32'h2);
    chk("warp_return_ready", 32'(cmd_ready), 32'd0);
    wait_ready();

    // Stealth time limit
    step(1'b1, CMD_STEALTH);
    st_cnt = 0; to_cnt = 0;
    for (int i = 0; i < 40 && mode_sel == 4'b1000; i++) begin
      st_cnt++;
      step(1'b0, CMD_NOP);
      to_cnt += int'(stealth_timeout);
    end
    chk("stealth_exit_mode", 32'(mode_sel), 32'h4);
    step(1'b0, CMD_NOP);
    to_cnt += int'(stealth_timeout);
    chk("stealth_len", 32'(st_cnt), 32'(STEALTH_MAX));
    chk("stealth_pulses", 32'(to_cnt), 32'd1);
    wait_ready();

    // RESET in the middle of a warp charge
    step(1'b1, CMD_WARP);
    step(1'b0, CMD_NOP);
    step(1'b0, CMD_NOP);
    step(1'b1, CMD_RESET);
    check_reset_values("midcharge_reset");

    // Disallowed and illegal commands from RESET
    step(1'b1, CMD_WARP);
    chk("warp_from_reset_err", 32'(cmd_err), 32'd1);
    step(1'b0, CMD_NOP);
    step(1'b1, 3'd7);
    chk("illegal_err", 32'(cmd_err), 32'd1);
    chk("illegal_mode", 32'(mode_sel), 32'h1);
    step(1'b0, CMD_NOP);

    // Asynchronous reset mid-cooldown in DEFENSE
    step(1'b1, CMD_DEFENSE);
    step(1'b0, CMD_NOP);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if      (r < 50) rc = CMD_NOP;
      else if (r < 53) rc = CMD_RESET;
      else if (r < 61) rc = CMD_ATTACK;
      else if (r < 69) rc = CMD_DEFENSE;
      else if (r < 77) rc = CMD_STEALTH;
      else if (r < 92) rc = CMD_WARP;
      else if (r < 96) rc = 3'd6;
      else             rc = 3'd7;
      step(1'($urandom_range(0, 1)), rc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flight_mode_controller.md
Name: flight_mode_controller

Overview:
Command-to-select stage sitting directly upstream of the per-axis position datapath. Accepts flight commands over a valid/ready handshake and drives the one-hot mode select (velocity source) and one-hot position select (reset / normal integrate / warp) consumed by each axis. Enforces mode-change cooldown, warp charge timing and a stealth time limit. One instance drives all three axes.

Parameters:
COOLDOWN, 4, cycles cmd_ready stays low after a mode change (min 1)
WARP_CHARGE, 8, cycles spent charging before the warp jump (min 1)
STEALTH_MAX, 16, max consecutive cycles in stealth before forced exit to defense (min 1)
CNT_W, 8, width of internal counters; must hold max(COOLDOWN, WARP_CHARGE, STEALTH_MAX)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd  in  3  0 NOP, 1 RESET, 2 ATTACK, 3 DEFENSE, 4 STEALTH, 5 WARP, 6-7 illegal
cmd_ready  out  1  controller can accept a non-RESET command
mode_sel  out  4  one-hot: 0001 reset, 0010 attack, 0100 defense, 1000 stealth
pos_sel  out  4  one-hot: 0001 reset, 0010 normal, 0100 warp; 1000 never driven
warp_busy  out  1  high in WARP_CHARGE and WARP states
stealth_timeout  out  1  one-cycle pulse on forced stealth exit
cmd_err  out  1  one-cycle pulse on illegal or disallowed command

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Reset values: state RESET, mode_sel=0001, pos_sel=0001, cmd_ready=1, warp_busy=0, pulses 0, all counters 0.
- All outputs are registered. Accept = cmd_valid & (cmd_ready | cmd==RESET). Effects appear the cycle after accept. A NOP is consumed with no effect.
- States:
  - RESET: mode 0001, pos 0001.
  - ATTACK / DEFENSE / STEALTH: mode 0010 / 0100 / 1000, pos 0010.
  - WARP_CHARGE: mode held, pos 0010.
  - WARP: mode held, pos 0100, exactly 1 cycle.
- Mode command (2/3/4) to a different mode: go to that state, load cooldown=COOLDOWN. cmd_ready is 0 for exactly COOLDOWN cycles starting the cycle after accept. Same-mode command: accepted, no state change, no cooldown.
- RESET command: always accepted, even when cmd_ready=0 or mid-warp. Next state is RESET; cooldown, charge and stealth counters clear; cmd_ready=1.
- WARP from ATTACK/DEFENSE/STEALTH:
  - Save the current mode, enter WARP_CHARGE for WARP_CHARGE cycles with cmd_ready=0.
  - Then WARP for 1 cycle.
  - Then return to the saved mode with pos 0010, load cooldown=COOLDOWN.
- WARP from RESET: consumed, cmd_err pulse, state unchanged.
- Illegal cmd 6/7: consumed, cmd_err pulse, state unchanged.
- Stealth limit:
  - The stealth counter increments each cycle in STEALTH and clears on leaving it, including into WARP_CHARGE. Returning from warp restarts the count.
  - On the STEALTH_MAX-th consecutive cycle, next state is DEFENSE, stealth_timeout pulses, and cooldown=COOLDOWN is loaded.
- Simultaneous events:
  - RESET beats everything.
  - An accepted mode or WARP command in the same cycle as stealth expiry wins, and stealth_timeout is suppressed.
  - Cooldown expiry and a new cmd_valid in the same cycle: the command is not accepted that cycle; cmd_ready rises first.
- Counters saturate at 0 and never wrap. mode_sel and pos_sel are always exactly one-hot.

Decomposition:
- Shared package flight_pkg holds:
  - command encodings (CMD_NOP … CMD_WARP);
  - one-hot constants MODE_RESET/ATTACK/DEFENSE/STEALTH and POS_RESET/NORMAL/WARP;
  - state enum flight_state_t.
  The axis position stage uses the same constants.
- One natural sub-module: cycle_counter (CNT_W-bit loadable down-counter with load, clear, zero flag), instantiated for cooldown and warp charge. The stealth counter is an up-counter in the top.

Test Plan:
- Release rst_n, then cmd=2 valid 1 cycle -> next cycle mode_sel=0010, pos_sel=0010; cmd_ready=0 for exactly 4 cycles, then 1.
- From ATTACK, cmd=5 -> warp_busy=1; pos_sel=0010 for 8 cycles, then 0100 for 1 cycle, then back to mode_sel=0010, pos_sel=0010, cmd_ready low 4 cycles.
- Enter STEALTH, hold NOP -> after 16 cycles in stealth: mode_sel=0100, stealth_timeout pulses once.
- Mid-charge (cycle 3 of 8), cmd=1 while cmd_ready=0 -> next cycle mode_sel=0001, pos_sel=0001, warp_busy=0, cmd_ready=1.
- From RESET, cmd=5, then cmd=7 -> each gives a cmd_err 1-cycle pulse; mode_sel stays 0001.
- Assert rst_n=0 asynchronously mid-cooldown in DEFENSE -> outputs reach reset values before the next clk edge.
